// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic-operation opcodes, opcode type and the S1 payload
// carried by alu_logop_pipe.
package alu_pkg;

  localparam int LOGOP_OP_W  = 5;
  localparam int LOGOP_MAX_W = 64;

  typedef logic [LOGOP_OP_W-1:0] logop_t;

  localparam logop_t LOGOP_AND = 5'd15;
  localparam logop_t LOGOP_OR  = 5'd14;
  localparam logop_t LOGOP_XOR = 5'd11;

  // Operands are held at the widest supported width; narrower units use the low bits.
  typedef struct packed {
    logic [LOGOP_MAX_W-1:0] a;
    logic [LOGOP_MAX_W-1:0] b;
    logop_t                 op;
  } logop_pld_t;

  function automatic logic logop_is_legal(input logop_t op);
    return (op == LOGOP_AND) || (op == LOGOP_OR) || (op == LOGOP_XOR);
  endfunction

endpackage

// File: rtl/alu_logop_core.sv
// Combinational WIDTH-bit AND/OR/XOR with illegal-opcode decode; illegal opcodes
// produce an all-zero result.
module alu_logop_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logop_t           op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             illegal_o
);

  always_comb begin
    res_o     = '0;
    illegal_o = 1'b0;
    case (op_i)
      LOGOP_AND: res_o = a_i & b_i;
      LOGOP_OR:  res_o = a_i | b_i;
      LOGOP_XOR: res_o = a_i ^ b_i;
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_logop_pipe.sv
// Two-stage valid/ready logic-operation unit (AND/OR/XOR) with synchronous flush.
// Build with ALU_LOGOP_FLAGS_EN defined to register zero_flag/illegal_op; otherwise both are tied to 0.
module alu_logop_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 5
) (
  input  logic             soc_clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ALU_dat1,
  input  logic [WIDTH-1:0] ALU_dat2,
  input  logic [OP_W-1:0]  decryptedOP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] LogOp_out,
  output logic             zero_flag,
  output logic             illegal_op
);

  logic                        s2_ld;
  logic                        s1_ld;
  logic                        s2_take;
  logic                        in_xfer;
  logic [OP_W+LOGOP_OP_W-1:0]  op_ext;
  logop_t                      op_norm;

  logic                        s1_vld_q, s1_vld_d;
  logop_pld_t                  s1_pld_q, s1_pld_d;
  logic                        out_vld_q, out_vld_d;
  logic [WIDTH-1:0]            res_q, res_d;

  logic [WIDTH-1:0]            core_res;
  logic                        core_ill;

  // Opcode bits above the package width can never name a legal operation.
  assign op_ext  = {{LOGOP_OP_W{1'b0}}, decryptedOP};
  assign op_norm = ((op_ext >> LOGOP_OP_W) != '0) ? logop_t'(0) : op_ext[LOGOP_OP_W-1:0];

  assign s2_ld    = !out_vld_q || out_ready;
  assign s1_ld    = !s1_vld_q || s2_ld;
  assign in_ready = s1_ld && !flush;
  assign in_xfer  = in_valid && in_ready;
  assign s2_take  = s2_ld && s1_vld_q && !flush;

  always_comb begin
    s1_pld_d = s1_pld_q;
    if (in_xfer) begin
      s1_pld_d.a  = LOGOP_MAX_W'(ALU_dat1);
      s1_pld_d.b  = LOGOP_MAX_W'(ALU_dat2);
      s1_pld_d.op = op_norm;
    end
  end

  assign s1_vld_d  = flush ? 1'b0 : (s1_ld ? in_xfer : s1_vld_q);
  assign out_vld_d = flush ? 1'b0 : (s2_ld ? s1_vld_q : out_vld_q);
  assign res_d     = s2_take ? core_res : res_q;

  // ---- Stage 1: operands and opcode ----
  always_ff @(posedge soc_clk or posedge reset) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_pld_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_pld_q <= s1_pld_d;
    end
  end

  alu_logop_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a_i       (s1_pld_q.a[WIDTH-1:0]),
    .b_i       (s1_pld_q.b[WIDTH-1:0]),
    .op_i      (s1_pld_q.op),
    .res_o     (core_res),
    .illegal_o (core_ill)
  );

  generate
    if (WIDTH < LOGOP_MAX_W) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^{s1_pld_q.a[LOGOP_MAX_W-1:WIDTH], s1_pld_q.b[LOGOP_MAX_W-1:WIDTH]};
    end
  endgenerate

  // ---- Stage 2: result and output valid ----
  always_ff @(posedge soc_clk or posedge reset) begin
    if (reset) begin
      out_vld_q <= 1'b0;
      res_q     <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      res_q     <= res_d;
    end
  end

  assign out_valid = out_vld_q;
  assign LogOp_out = res_q;

`ifdef ALU_LOGOP_FLAGS_EN
  logic zero_q, zero_d;
  logic ill_q, ill_d;

  assign zero_d = s2_take ? (core_res == '0) : zero_q;
  assign ill_d  = s2_take ? core_ill : ill_q;

  always_ff @(posedge soc_clk or posedge reset) begin
    if (reset) begin
      zero_q <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      ill_q  <= ill_d;
    end
  end

  assign zero_flag  = zero_q;
  assign illegal_op = ill_q;
`else
  logic unused_ill;
  assign unused_ill = core_ill;
  assign zero_flag  = 1'b0;
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_alu_logop_pipe.sv
// Scoreboard bench for alu_logop_pipe: directed timing checks plus a queue of expected results.
module tb_alu_logop_pipe;

  logic        soc_clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] ALU_dat1, ALU_dat2, LogOp_out;
  logic [4:0]  decryptedOP;
  logic        zero_flag, illegal_op;

  typedef struct {
    logic [31:0] res;
    logic        zf;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] bp_a[4] = '{32'h1111_0000, 32'h0F0F_0F0F, 32'h8000_0001, 32'hDEAD_BEEF};
  logic [31:0] bp_b[4] = '{32'h0101_FFFF, 32'hFFFF_0000, 32'h0000_0001, 32'h0000_FFFF};
  logic [4:0]  bp_o[4] = '{5'd14, 5'd15, 5'd11, 5'd15};
  logic [4:0]  rnd_ops[5] = '{5'd15, 5'd14, 5'd11, 5'd7, 5'd0};

  alu_logop_pipe #(.WIDTH(32), .OP_W(5)) dut (
    .soc_clk     (soc_clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ALU_dat1    (ALU_dat1),
    .ALU_dat2    (ALU_dat2),
    .decryptedOP (decryptedOP),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .LogOp_out   (LogOp_out),
    .zero_flag   (zero_flag),
    .illegal_op  (illegal_op)
  );

  always #5 soc_clk = ~soc_clk;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    exp_t e;
    case (op)
      5'd15:   e.res = a & b;
      5'd14:   e.res = a | b;
      5'd11:   e.res = a ^ b;
      default: e.res = 32'h0;
    endcase
`ifdef ALU_LOGOP_FLAGS_EN
    e.zf  = (e.res == 32'h0);
    e.ill = !((op == 5'd15) || (op == 5'd14) || (op == 5'd11));
`else
    e.zf  = 1'b0;
    e.ill = 1'b0;
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop on output transfer, push on input transfer, drop all on flush/reset.
  always @(negedge soc_clk) begin
    if (reset || flush) begin
      exp_q.delete();
      if (flush && !reset) check("flush_in_ready", {63'b0, in_ready}, 64'd0);
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_result", {32'b0, LogOp_out}, {32'b0, mon_e.res});
          check("sb_zero",   {63'b0, zero_flag}, {63'b0, mon_e.zf});
          check("sb_illegal", {63'b0, illegal_op}, {63'b0, mon_e.ill});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(ALU_dat1, ALU_dat2, decryptedOP));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the edge that accepted the input.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    logic acc;
    int   guard;
    ALU_dat1 = a; ALU_dat2 = b; decryptedOP = op; in_valid = 1'b1;
    guard = 0;
    forever begin
      #1 acc = in_ready;
      @(posedge soc_clk); #1;
      if (acc) break;
      guard++;
      if (guard > 20) begin
        check("send_timeout", 64'd0, 64'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int acc_cnt;
    int k;
    int guard;
    logic acc;
    exp_t e;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ALU_dat1 = '0; ALU_dat2 = '0; decryptedOP = '0;
    repeat (3) @(posedge soc_clk);
    #1;
    check("rst_in_ready",  {63'b0, in_ready},   64'd1);
    check("rst_out_valid", {63'b0, out_valid},  64'd0);
    check("rst_result",    {32'b0, LogOp_out},  64'd0);
    check("rst_zero",      {63'b0, zero_flag},  64'd0);
    check("rst_illegal",   {63'b0, illegal_op}, 64'd0);
    reset = 1'b0;
    @(posedge soc_clk); #1;

    // AND with two-cycle latency
    send(32'hF0F0_1234, 32'hFF00_FF00, 5'd15);
    check("and_early_vld", {63'b0, out_valid}, 64'd0);
    @(posedge soc_clk); #1;
    check("and_vld",  {63'b0, out_valid}, 64'd1);
    check("and_res",  {32'b0, LogOp_out}, 64'hF000_1200);
    check("and_zero", {63'b0, zero_flag}, 64'd0);
    @(posedge soc_clk); #1;

    // Back-to-back OR then XOR
    send(32'h0000_00FF, 32'h0000_FF00, 5'd14);
    send(32'hAAAA_AAAA, 32'hAAAA_AAAA, 5'd11);
    check("b2b_vld0", {63'b0, out_valid}, 64'd1);
    check("b2b_res0", {32'b0, LogOp_out}, 64'h0000_FFFF);
    @(posedge soc_clk); #1;
    e = model(32'hAAAA_AAAA, 32'hAAAA_AAAA, 5'd11);
    check("b2b_vld1",  {63'b0, out_valid}, 64'd1);
    check("b2b_res1",  {32'b0, LogOp_out}, 64'd0);
    check("b2b_zero1", {63'b0, zero_flag}, {63'b0, e.zf});
    @(posedge soc_clk); #1;

    // Illegal opcode
    send(32'h1234_5678, 32'h9ABC_DEF0, 5'd7);
    @(posedge soc_clk); #1;
    e = model(32'h1234_5678, 32'h9ABC_DEF0, 5'd7);
    check("ill_res",  {32'b0, LogOp_out},  64'd0);
    check("ill_flag", {63'b0, illegal_op}, {63'b0, e.ill});
    @(posedge soc_clk); #1;

    // Backpressure: four offered, two fit
    out_ready = 1'b0; acc_cnt = 0; k = 0;
    for (int c = 0; c < 6; c++) begin
      ALU_dat1 = bp_a[k]; ALU_dat2 = bp_b[k]; decryptedOP = bp_o[k];
      in_valid = (k < 4);
      #1 acc = in_valid && in_ready;
      @(posedge soc_clk); #1;
      if (acc) begin acc_cnt++; k++; end
    end
    in_valid = 1'b0;
    e = model(bp_a[0], bp_b[0], bp_o[0]);
    check("bp_accepted", acc_cnt, 64'd2);
    check("bp_in_ready", {63'b0, in_ready}, 64'd0);
    repeat (3) @(posedge soc_clk);
    #1;
    check("bp_stable_vld", {63'b0, out_valid}, 64'd1);
    check("bp_stable_res", {32'b0, LogOp_out}, {32'b0, e.res});
    out_ready = 1'b1;
    repeat (3) @(posedge soc_clk);
    #1;
    check("bp_drain_rdy", {63'b0, in_ready}, 64'd1);
    check("bp_drain_vld", {63'b0, out_valid}, 64'd0);
    check("bp_drain_q",   exp_q.size(), 64'd0);

    // Flush with two in flight; flush beats out_ready
    out_ready = 1'b0;
    send(32'hFFFF_FFFF, 32'h1234_0000, 5'd15);
    send(32'h0000_0001, 32'h0000_0002, 5'd14);
    flush = 1'b1; out_ready = 1'b1;
    #1 check("flush_rdy", {63'b0, in_ready}, 64'd0);
    @(posedge soc_clk); #1;
    flush = 1'b0;
    check("flush_vld", {63'b0, out_valid}, 64'd0);
    repeat (3) begin
      @(posedge soc_clk); #1;
      check("flush_quiet", {63'b0, out_valid}, 64'd0);
    end
    send(32'hC3C3_C3C3, 32'h0FF0_0FF0, 5'd11);
    check("post_flush_early", {63'b0, out_valid}, 64'd0);
    @(posedge soc_clk); #1;
    check("post_flush_vld", {63'b0, out_valid}, 64'd1);
    check("post_flush_res", {32'b0, LogOp_out}, 64'hCC33_CC33);
    @(posedge soc_clk); #1;

    // Asynchronous reset with a full pipeline
    out_ready = 1'b0;
    send(32'h5555_5555, 32'hFFFF_FFFF, 5'd15);
    send(32'h0F0F_0F0F, 32'hF0F0_F0F0, 5'd14);
    #2 reset = 1'b1;
    #1;
    check("arst_vld",  {63'b0, out_valid},  64'd0);
    check("arst_res",  {32'b0, LogOp_out},  64'd0);
    check("arst_rdy",  {63'b0, in_ready},   64'd1);
    check("arst_ill",  {63'b0, illegal_op}, 64'd0);
    @(posedge soc_clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    @(posedge soc_clk); #1;
    check("arst_after_vld", {63'b0, out_valid}, 64'd0);

    // Random stream with random backpressure
    for (int n = 0; n < 24; n++) begin
      ALU_dat1 = $urandom; ALU_dat2 = $urandom;
      decryptedOP = rnd_ops[$urandom_range(0, 4)];
      in_valid = 1'b1;
      guard = 0;
      forever begin
        out_ready = ($urandom_range(0, 3) != 0);
        #1 acc = in_ready;
        @(posedge soc_clk); #1;
        if (acc) break;
        guard++;
        if (guard > 50) begin
          check("rnd_timeout", 64'd0, 64'd1);
          break;
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge soc_clk);
    #1;
    check("rnd_drain_q",   exp_q.size(), 64'd0);
    check("rnd_drain_vld", {63'b0, out_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
